store_queue: RTL and testbench

Circular store queue that sits beside the load queue in the R10000-style LSQ. It allocates entries for up to `WIDTH` stores per cycle at dispatch and captures their address and data at execute. Younger loads search it for store-to-load forwarding. ROB-retired stores are marked committed and drained in order to the data cache over a valid/ready handshake.

---
 rtl/store_queue.sv | 184 ++++++++++++++++++
 tb/tb_store_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// Circular LSQ store queue: dispatch alloc, execute capture, youngest-older load forwarding, in-order drain over valid/ready.
// Outputs are combinational from state; mem_* held stable under !mem_ready. Define SQ_FORWARD_EN to forward, else matches stall.
module store_queue #(
  parameter int SQ_SIZE  = 8,
  parameter int WIDTH    = 2,
  parameter int XLEN     = 32,
  parameter int ROB_SIZE = 32,
  localparam int P  = $clog2(SQ_SIZE),
  localparam int RW = $clog2(ROB_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rollback,
  input  logic [WIDTH-1:0]           storeen,
  input  logic [WIDTH-1:0][RW-1:0]   robnum,
  output logic [WIDTH-1:0][P-1:0]    sqp,
  output logic [WIDTH-1:0]           full,
  input  logic [WIDTH-1:0]           sten,
  input  logic [WIDTH-1:0][P-1:0]    st_sqp,
  input  logic [WIDTH-1:0][XLEN-1:0] st_addr,
  input  logic [WIDTH-1:0][XLEN-1:0] st_data,
  input  logic                       ld_valid,
  input  logic [XLEN-1:0]            ld_addr,
  input  logic [P-1:0]               ld_sqp,
  output logic                       ld_hit,
  output logic [XLEN-1:0]            ld_data,
  output logic                       ld_stall,
  input  logic [WIDTH-1:0]           retirest,
  output logic                       mem_valid,
  output logic [XLEN-1:0]            mem_addr,
  output logic [XLEN-1:0]            mem_data,
  input  logic                       mem_ready,
  output logic                       empty
);

  logic [SQ_SIZE-1:0]         r_valid, r_addr_valid, r_committed;
  logic [XLEN-1:0]            r_addr [SQ_SIZE];
  logic [XLEN-1:0]            r_data [SQ_SIZE];
  logic [SQ_SIZE-1:0][RW-1:0] r_robnum;
  logic [P-1:0]               r_head, r_cmt, r_tail;
  logic [P:0]                 r_count;

  logic [P:0]         w_free, w_n_alloc, w_n_ret, w_rb_count;
  logic [P-1:0]       w_pre, w_cmt_next, w_head_next, w_rb_diff, w_dist, w_idx;
  logic [WIDTH-1:0]   w_alloc;
  logic [SQ_SIZE-1:0] w_cmt_set, w_keep;
  logic               w_drain, w_match;
`ifdef SQ_FORWARD_EN
  logic [XLEN-1:0]    w_match_data;
`endif

  // ROB tags are kept per entry for debug visibility; nothing in this block consumes them.
  logic w_unused_robnum;
  assign w_unused_robnum = ^r_robnum;

  assign w_free = (P+1)'(SQ_SIZE) - r_count;

  always_comb begin
    sqp       = '0;
    full      = '0;
    w_alloc   = '0;
    w_n_alloc = '0;
    w_n_ret   = '0;
    w_pre     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      full[i]    = (w_free <= (P+1)'(i));
      sqp[i]     = r_tail + w_pre;
      w_alloc[i] = storeen[i] & ~full[i] & ~rollback;
      if (storeen[i]) w_pre = w_pre + 1'b1;
      if (w_alloc[i]) w_n_alloc = w_n_alloc + 1'b1;
      if (retirest[i]) w_n_ret = w_n_ret + 1'b1;
    end
  end

  always_comb begin
    w_cmt_set = '0;
    for (int k = 0; k < WIDTH; k++)
      if ((P+1)'(k) < w_n_ret) w_cmt_set[r_cmt + P'(k)] = 1'b1;
  end

  assign mem_valid   = r_valid[r_head] & r_committed[r_head];
  assign mem_addr    = mem_valid ? r_addr[r_head] : '0;
  assign mem_data    = mem_valid ? r_data[r_head] : '0;
  assign empty       = (r_count == '0);
  assign w_drain     = mem_valid & mem_ready;
  assign w_cmt_next  = r_cmt + w_n_ret[P-1:0];
  assign w_head_next = r_head + {{(P-1){1'b0}}, w_drain};
  assign w_keep      = r_committed | w_cmt_set;

  // tail-head alone is ambiguous when every surviving entry is committed and the ring is full.
  always_comb begin
    w_rb_diff  = w_cmt_next - w_head_next;
    w_rb_count = {1'b0, w_rb_diff};
    if (w_rb_diff == '0 && r_valid[w_head_next] && w_keep[w_head_next])
      w_rb_count = (P+1)'(SQ_SIZE);
  end

  always_comb begin
    w_dist  = ld_sqp - r_head;
    w_idx   = '0;
    w_match = 1'b0;
`ifdef SQ_FORWARD_EN
    w_match_data = '0;
`endif
    for (int k = 0; k < SQ_SIZE; k++) begin
      w_idx = r_head + P'(k);
      if (P'(k) < w_dist && r_valid[w_idx] && r_addr_valid[w_idx] && r_addr[w_idx] == ld_addr) begin
        w_match = 1'b1;
`ifdef SQ_FORWARD_EN
        w_match_data = r_data[w_idx];
`endif
      end
    end
  end

`ifdef SQ_FORWARD_EN
  assign ld_hit   = ld_valid & w_match;
  assign ld_data  = (ld_valid & w_match) ? w_match_data : '0;
  assign ld_stall = 1'b0;
`else
  assign ld_hit   = 1'b0;
  assign ld_data  = '0;
  assign ld_stall = ld_valid & w_match;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid      <= '0;
      r_addr_valid <= '0;
      r_committed  <= '0;
      r_robnum     <= '0;
      for (int j = 0; j < SQ_SIZE; j++) begin
        r_addr[j] <= '0;
        r_data[j] <= '0;
      end
      r_head  <= '0;
      r_cmt   <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sten[i]) begin
          r_addr[st_sqp[i]]       <= st_addr[i];
          r_data[st_sqp[i]]       <= st_data[i];
          r_addr_valid[st_sqp[i]] <= 1'b1;
        end
      end
      for (int j = 0; j < SQ_SIZE; j++)
        if (w_cmt_set[j]) r_committed[j] <= 1'b1;
      if (w_drain) begin
        r_valid[r_head]      <= 1'b0;
        r_addr_valid[r_head] <= 1'b0;
        r_committed[r_head]  <= 1'b0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (w_alloc[i]) begin
          r_valid[sqp[i]]      <= 1'b1;
          r_addr_valid[sqp[i]] <= 1'b0;
          r_committed[sqp[i]]  <= 1'b0;
          r_robnum[sqp[i]]     <= robnum[i];
        end
      end
      if (rollback) begin
        for (int j = 0; j < SQ_SIZE; j++) begin
          if (!w_keep[j]) begin
            r_valid[j]      <= 1'b0;
            r_addr_valid[j] <= 1'b0;
            r_committed[j]  <= 1'b0;
          end
        end
      end
      r_head <= w_head_next;
      r_cmt  <= w_cmt_next;
      if (rollback) begin
        r_tail  <= w_cmt_next;
        r_count <= w_rb_count;
      end else begin
        r_tail  <= r_tail + w_n_alloc[P-1:0];
        r_count <= r_count + w_n_alloc - (P+1)'(w_drain);
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: stimulus pushes expected loads/drains, a negedge monitor pops and compares.
module tb_store_queue;
  localparam int SQ = 8, W = 2, XL = 32, RB = 32, P = 3, RW = 5;

  logic clock, reset, rollback;
  logic [W-1:0]          storeen;
  logic [W-1:0][RW-1:0]  robnum;
  logic [W-1:0][P-1:0]   sqp;
  logic [W-1:0]          full;
  logic [W-1:0]          sten;
  logic [W-1:0][P-1:0]   st_sqp;
  logic [W-1:0][XL-1:0]  st_addr, st_data;
  logic                  ld_valid;
  logic [XL-1:0]         ld_addr;
  logic [P-1:0]          ld_sqp;
  logic                  ld_hit, ld_stall;
  logic [XL-1:0]         ld_data;
  logic [W-1:0]          retirest;
  logic                  mem_valid, mem_ready, empty;
  logic [XL-1:0]         mem_addr, mem_data;

  store_queue #(.SQ_SIZE(SQ), .WIDTH(W), .XLEN(XL), .ROB_SIZE(RB)) dut (
    .clock(clock), .reset(reset), .rollback(rollback), .storeen(storeen), .robnum(robnum),
    .sqp(sqp), .full(full), .sten(sten), .st_sqp(st_sqp), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_sqp(ld_sqp), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_stall(ld_stall), .retirest(retirest), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .empty(empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed { logic hit; logic [XL-1:0] data; logic stall; } ld_exp_t;
  typedef struct packed { logic [XL-1:0] addr; logic [XL-1:0] data; } mem_exp_t;

  ld_exp_t  ld_q[$];
  mem_exp_t mem_q[$];
  ld_exp_t  mon_ld;
  mem_exp_t mon_mem;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic ld_exp_t ld_expect(input logic m, input logic [XL-1:0] d);
    ld_exp_t e;
`ifdef SQ_FORWARD_EN
    e.hit = m; e.data = m ? d : '0; e.stall = 1'b0;
`else
    e.hit = 1'b0; e.data = '0; e.stall = m;
`endif
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (ld_valid) begin
        if (ld_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ld_unexpected: got lookup with no expectation queued");
        end else begin
          mon_ld = ld_q.pop_front();
          chk("ld_hit", 64'(ld_hit), 64'(mon_ld.hit));
          chk("ld_data", 64'(ld_data), 64'(mon_ld.data));
          chk("ld_stall", 64'(ld_stall), 64'(mon_ld.stall));
        end
      end
      if (mem_valid && mem_ready) begin
        if (mem_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mem_unexpected: got drain addr %0h with none queued", mem_addr);
        end else begin
          mon_mem = mem_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(mon_mem.addr));
          chk("mem_data", 64'(mem_data), 64'(mon_mem.data));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic lookup(input logic [XL-1:0] a, input logic [P-1:0] s, input logic m, input logic [XL-1:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_sqp = s;
    ld_q.push_back(ld_expect(m, d));
    tick;
    ld_valid = 1'b0;
  endtask

  task automatic push_mem(input logic [XL-1:0] a, input logic [XL-1:0] d);
    mem_exp_t e;
    e.addr = a; e.data = d;
    mem_q.push_back(e);
  endtask

  task automatic wait_empty(input string name);
    int i;
    i = 0;
    while (!empty && i < 30) begin
      tick;
      i++;
    end
    #1;
    chk(name, 64'(empty), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rollback = 1'b0; storeen = '0; robnum = '0; sten = '0; st_sqp = '0;
    st_addr = '0; st_data = '0; ld_valid = 1'b0; ld_addr = '0; ld_sqp = '0;
    retirest = '0; mem_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    #1;
    chk("rst_sqp", 64'(sqp), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_mem", 64'({mem_valid, mem_addr, mem_data}), 64'd0);
    chk("rst_ld", 64'({ld_hit, ld_stall, ld_data}), 64'd0);

    // Fill: three double dispatches, one single, then a double that only has room for slot 0.
    storeen = 2'b11; robnum = {5'd1, 5'd0};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("fill_sqp", 64'(sqp), 64'({3'(2*c+1), 3'(2*c)}));
      chk("fill_full", 64'(full), 64'd0);
      tick;
    end
    storeen = 2'b01;
    #1;
    chk("fill_sqp_single", 64'(sqp), 64'({3'd7, 3'd6}));
    tick;
    storeen = 2'b11;
    #1;
    chk("full_one_free", 64'(full), 64'(2'b10));
    chk("wrap_sqp_at7", 64'(sqp), 64'({3'd0, 3'd7}));
    tick;
    #1;
    chk("full_all", 64'(full), 64'(2'b11));
    chk("full_not_empty", 64'(empty), 64'd0);
    tick;
    storeen = 2'b00;
    #1;
    chk("full_hold", 64'(full), 64'(2'b11));
    chk("full_sqp_tail0", 64'(sqp), 64'd0);

    // Execute entries 0..3.
    sten = 2'b11; st_sqp = {3'd1, 3'd0};
    st_addr = {32'h100, 32'h200}; st_data = {32'hAA, 32'h10};
    tick;
    st_sqp = {3'd3, 3'd2};
    st_addr = {32'h100, 32'h300}; st_data = {32'hBB, 32'h30};
    tick;
    sten = 2'b00;
    ld_addr = 32'h100; ld_sqp = 3'd4;
    #1;
    chk("no_commit_mem_valid", 64'(mem_valid), 64'd0);
    chk("ld_gated", 64'({ld_hit, ld_stall, ld_data}), 64'd0);

    lookup(32'h100, 3'd4, 1'b1, 32'hBB);
    lookup(32'h100, 3'd2, 1'b1, 32'hAA);
    lookup(32'h100, 3'd1, 1'b0, 32'h0);
    lookup(32'h100, 3'd0, 1'b0, 32'h0);
    lookup(32'h200, 3'd4, 1'b1, 32'h10);
    lookup(32'h999, 3'd7, 1'b0, 32'h0);
    // Execute into entry 4 in the same cycle as a lookup: not yet visible.
    sten = 2'b01; st_sqp = {3'd0, 3'd4}; st_addr = {32'h0, 32'h100}; st_data = {32'h0, 32'hCC};
    lookup(32'h100, 3'd5, 1'b1, 32'hBB);
    sten = 2'b00;
    lookup(32'h100, 3'd5, 1'b1, 32'hCC);
    lookup(32'h100, 3'd7, 1'b1, 32'hCC);

    // Retire 0,1 and hold the D-cache off for three cycles.
    retirest = 2'b11; mem_ready = 1'b0;
    push_mem(32'h200, 32'h10);
    push_mem(32'h100, 32'hAA);
    #1;
    chk("retire_cycle_mem_valid", 64'(mem_valid), 64'd0);
    tick;
    retirest = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_mem_valid", 64'(mem_valid), 64'd1);
      chk("hold_mem_addr", 64'(mem_addr), 64'h200);
      chk("hold_mem_data", 64'(mem_data), 64'h10);
      tick;
    end
    mem_ready = 1'b1;
    tick; tick;
    #1;
    chk("drain2_mem_valid", 64'(mem_valid), 64'd0);
    chk("drain2_full", 64'(full), 64'd0);
    chk("drain2_queue", 64'(mem_q.size()), 64'd0);
    lookup(32'h100, 3'd2, 1'b0, 32'h0);

    // Rollback with a same-cycle retire of 2,3 and an ignored dispatch.
    mem_ready = 1'b0; retirest = 2'b11; rollback = 1'b1; storeen = 2'b11;
    push_mem(32'h300, 32'h30);
    push_mem(32'h100, 32'hBB);
    tick;
    retirest = 2'b00; rollback = 1'b0; storeen = 2'b00;
    #1;
    chk("rb_tail", 64'(sqp), 64'({3'd4, 3'd4}));
    chk("rb_empty", 64'(empty), 64'd0);
    chk("rb_full", 64'(full), 64'd0);
    chk("rb_mem_addr", 64'({mem_valid, mem_addr}), 64'({1'b1, 32'h300}));
    lookup(32'h100, 3'd6, 1'b1, 32'hBB);
    mem_ready = 1'b1;
    wait_empty("rb_drain_empty");
    chk("rb_mem_idle", 64'(mem_valid), 64'd0);

    // Walk head/tail to 7.
    storeen = 2'b11;
    #1;
    chk("walk_sqp_a", 64'(sqp), 64'({3'd5, 3'd4}));
    tick;
    storeen = 2'b01;
    #1;
    chk("walk_sqp_b", 64'(sqp), 64'({3'd7, 3'd6}));
    tick;
    storeen = 2'b00;
    sten = 2'b11; st_sqp = {3'd5, 3'd4}; st_addr = {32'h504, 32'h500}; st_data = {32'h2, 32'h1};
    tick;
    sten = 2'b01; st_sqp = {3'd0, 3'd6}; st_addr = {32'h0, 32'h508}; st_data = {32'h0, 32'h3};
    tick;
    sten = 2'b00;
    retirest = 2'b11;
    push_mem(32'h500, 32'h1);
    push_mem(32'h504, 32'h2);
    tick;
    retirest = 2'b01;
    push_mem(32'h508, 32'h3);
    #1;
    chk("retire_next_cycle_valid", 64'(mem_valid), 64'd1);
    tick;
    retirest = 2'b00;
    wait_empty("walk_empty");

    // Wrap at head=tail=7.
    storeen = 2'b11;
    #1;
    chk("wrap_sqp", 64'(sqp), 64'({3'd0, 3'd7}));
    tick;
    storeen = 2'b00;
    sten = 2'b11; st_sqp = {3'd0, 3'd7}; st_addr = {32'h80, 32'h40}; st_data = {32'h22, 32'h11};
    tick;
    sten = 2'b00;
    lookup(32'h40, 3'd1, 1'b1, 32'h11);
    lookup(32'h80, 3'd1, 1'b1, 32'h22);
    lookup(32'h80, 3'd0, 1'b0, 32'h0);
    lookup(32'h40, 3'd0, 1'b1, 32'h11);
    retirest = 2'b11;
    push_mem(32'h40, 32'h11);
    push_mem(32'h80, 32'h22);
    tick;
    retirest = 2'b00;
    wait_empty("wrap_empty");

    tick;
    chk("ld_queue_drained", 64'(ld_q.size()), 64'd0);
    chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
